// File: rtl/piso_serializer_pkg.sv
// -----------------------------------------------------------------------------
// piso_serializer_pkg
//   Shared constants and types for the parallel-in / serial-out transmitter.
//   - PISO_WIDTH_DEFAULT     : default word width in bits.
//   - PISO_MSB_FIRST_DEFAULT : default shift order (1 = MSB first).
//   - piso_state_e           : transmitter state encoding (IDLE / SHIFT).
// -----------------------------------------------------------------------------
package piso_serializer_pkg;

  localparam int unsigned PISO_WIDTH_DEFAULT     = 4;
  localparam bit          PISO_MSB_FIRST_DEFAULT = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

endpackage : piso_serializer_pkg

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Parallel-in, serial-out transmitter. A WIDTH-bit word is accepted over a
//   valid/ready handshake and shifted out one bit per clock on ser_out, framed
//   by ser_valid, frame_start and last_bit. A new word may be accepted during
//   the last bit of the current one, giving gapless back-to-back words.
//
// Parameters
//   WIDTH      : bits per word (>= 2).
//   MSB_FIRST  : 1 = MSB transmitted first, 0 = LSB transmitted first.
//
// Ports
//   clock       in   rising-edge clock
//   clear       in   asynchronous active-low reset
//   load_data   in   [WIDTH-1:0] parallel word to transmit
//   load_valid  in   load_data is valid this cycle
//   load_ready  out  a word can be accepted this cycle
//   ser_out     out  serial data bit
//   ser_valid   out  ser_out carries a valid bit
//   frame_start out  first bit of a word
//   last_bit    out  final bit of a word
// -----------------------------------------------------------------------------
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = PISO_WIDTH_DEFAULT,
  parameter bit          MSB_FIRST = PISO_MSB_FIRST_DEFAULT
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             last_bit
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] sreg_q,  sreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic shifting;
  logic at_last;
  logic accept;

  // Everything below is decoded from registered state only, so the framing
  // outputs cannot glitch on load_valid and load_ready has no path from it.
  assign shifting   = (state_q == SHIFT);
  assign at_last    = shifting && (cnt_q == CNT_LAST);
  assign load_ready = !shifting || at_last;
  assign accept     = load_valid && load_ready;

  // The register is shifted rather than indexed: the outgoing bit always sits
  // at a fixed end (MSB for MSB-first, LSB for LSB-first).
  assign ser_out     = shifting && (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
  assign ser_valid   = shifting;
  assign frame_start = shifting && (cnt_q == '0);
  assign last_bit    = at_last;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;

    if (accept) begin
      // Covers both a load from IDLE and a reload during the last bit.
      sreg_d  = load_data;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (shifting) begin
      if (MSB_FIRST) begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      end else begin
        sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
      end
      if (at_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Directed bench for piso_serializer at WIDTH=4. One instance runs MSB-first,
//   a second runs LSB-first. The MSB-first output drives a 4-stage serial
//   shift-register chain (B/C/D/E) acting as the loopback sink.
//   Per-cycle observations are packed as {ser_valid, ser_out, frame_start,
//   last_bit, load_ready}.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  localparam int W = 4;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  logic [W-1:0] ld_m = '0, ld_l = '0;
  logic         lv_m = 1'b0, lv_l = 1'b0;
  logic         lr_m, so_m, sv_m, fs_m, lb_m;
  logic         lr_l, so_l, sv_l, fs_l, lb_l;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clock(clock), .clear(clear), .load_data(ld_m), .load_valid(lv_m),
    .load_ready(lr_m), .ser_out(so_m), .ser_valid(sv_m),
    .frame_start(fs_m), .last_bit(lb_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clock(clock), .clear(clear), .load_data(ld_l), .load_valid(lv_l),
    .load_ready(lr_l), .ser_out(so_l), .ser_valid(sv_l),
    .frame_start(fs_l), .last_bit(lb_l)
  );

  // Downstream 4-stage serial chain fed by the MSB-first transmitter.
  logic ch_b, ch_c, ch_d, ch_e;
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ch_b <= 1'b0; ch_c <= 1'b0; ch_d <= 1'b0; ch_e <= 1'b0;
    end else begin
      ch_b <= so_m; ch_c <= ch_b; ch_d <= ch_c; ch_e <= ch_d;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic test_reset();
    logic [4:0] obs;
    clear = 1'b1;
    #2 clear = 1'b0;
    #1;
    obs = {sv_m, so_m, fs_m, lb_m, lr_m};
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_bad++; $display("FAIL reset_msb: got %b want 00001", obs);
    end
    obs = {sv_l, so_l, fs_l, lb_l, lr_l};
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_bad++; $display("FAIL reset_lsb: got %b want 00001", obs);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    obs = {sv_m, so_m, fs_m, lb_m, lr_m};
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_bad++; $display("FAIL idle_after_reset: got %b want 00001", obs);
    end
  endtask

  task automatic test_msb_first();
    logic [0:3] exp_so;
    logic [4:0] obs, exp;
    exp_so = 4'b1011;
    @(negedge clock);
    ld_m = 4'b1011; lv_m = 1'b1;
    @(negedge clock);
    lv_m = 1'b0; ld_m = '0;
    for (int k = 0; k < 4; k++) begin
      obs = {sv_m, so_m, fs_m, lb_m, lr_m};
      exp = {1'b1, exp_so[k], (k == 0), (k == 3), (k == 3)};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL msb_first k=%0d: got %b want %b", k, obs, exp);
      end
      @(negedge clock);
    end
    obs = {sv_m, so_m, fs_m, lb_m, lr_m};
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_bad++; $display("FAIL msb_first_end: got %b want 00001", obs);
    end
  endtask

  task automatic test_lsb_first();
    logic [0:3] exp_so;
    logic [4:0] obs, exp;
    exp_so = 4'b1101;
    @(negedge clock);
    ld_l = 4'b1011; lv_l = 1'b1;
    @(negedge clock);
    lv_l = 1'b0; ld_l = '0;
    for (int k = 0; k < 4; k++) begin
      obs = {sv_l, so_l, fs_l, lb_l, lr_l};
      exp = {1'b1, exp_so[k], (k == 0), (k == 3), (k == 3)};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL lsb_first k=%0d: got %b want %b", k, obs, exp);
      end
      @(negedge clock);
    end
    obs = {sv_l, so_l, fs_l, lb_l, lr_l};
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_bad++; $display("FAIL lsb_first_end: got %b want 00001", obs);
    end
  endtask

  // Second word is presented from T+1 and held; it must only be taken at T+4.
  task automatic test_two_words(input string name, input logic [3:0] w1,
                                input logic [3:0] w2, input logic [0:7] exp_so);
    logic [4:0] obs, exp;
    @(negedge clock);
    ld_m = w1; lv_m = 1'b1;
    @(negedge clock);
    ld_m = w2;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        lv_m = 1'b0; ld_m = 4'b0000;
      end
      obs = {sv_m, so_m, fs_m, lb_m, lr_m};
      exp = {1'b1, exp_so[k], (k % 4 == 0), (k % 4 == 3), (k % 4 == 3)};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL %s k=%0d: got %b want %b", name, k, obs, exp);
      end
      @(negedge clock);
    end
    obs = {sv_m, so_m, fs_m, lb_m, lr_m};
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_bad++; $display("FAIL %s_end: got %b want 00001", name, obs);
    end
  endtask

  task automatic test_back_to_back();
    test_two_words("back_to_back", 4'b1011, 4'b0110, 8'b1011_0110);
  endtask

  task automatic test_hold_off();
    test_two_words("hold_off", 4'b1011, 4'b1111, 8'b1011_1111);
  endtask

  task automatic test_reset_mid_word();
    logic [0:3] exp_so;
    logic [4:0] obs, exp;
    @(negedge clock);
    ld_m = 4'b1111; lv_m = 1'b1;
    @(negedge clock);
    lv_m = 1'b0; ld_m = '0;
    @(negedge clock);
    obs = {sv_m, so_m, fs_m, lb_m, lr_m};
    n_cmp++;
    if (obs !== 5'b11000) begin
      n_bad++; $display("FAIL mid_word_before_reset: got %b want 11000", obs);
    end
    #2 clear = 1'b0;
    #1;
    obs = {sv_m, so_m, fs_m, lb_m, lr_m};
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_bad++; $display("FAIL async_reset: got %b want 00001", obs);
    end
    @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    obs = {sv_m, so_m, fs_m, lb_m, lr_m};
    n_cmp++;
    if (obs !== 5'b00001) begin
      n_bad++; $display("FAIL idle_after_release: got %b want 00001", obs);
    end
    exp_so = 4'b0110;
    ld_m = 4'b0110; lv_m = 1'b1;
    @(negedge clock);
    lv_m = 1'b0; ld_m = '0;
    for (int k = 0; k < 4; k++) begin
      obs = {sv_m, so_m, fs_m, lb_m, lr_m};
      exp = {1'b1, exp_so[k], (k == 0), (k == 3), (k == 3)};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL after_reset_word k=%0d: got %b want %b", k, obs, exp);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_loopback();
    logic [0:3] exp_so;
    logic       exp_e;
    exp_so = 4'b1011;
    repeat (5) @(negedge clock);
    ld_m = 4'b1011; lv_m = 1'b1;
    @(negedge clock);
    lv_m = 1'b0; ld_m = '0;
    for (int k = 0; k < 9; k++) begin
      exp_e = (k >= 4 && k < 8) ? exp_so[k-4] : 1'b0;
      n_cmp++;
      if (ch_e !== exp_e) begin
        n_bad++; $display("FAIL loopback_e k=%0d: got %b want %b", k, ch_e, exp_e);
      end
      @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_hold_off();
    test_reset_mid_word();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_piso_serializer

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready load handshake and shifts the word out one bit per clock on ser_out.
- It is the source end of the serial bit chain: its ser_out drives the A input of the serial shift-register chain (the 4-stage B/C/D/E chain).
- ser_valid, frame_start and last_bit frame each word for the downstream logic.
- Supports gapless back-to-back words.

Parameters:
- WIDTH, 4, bits per word; legal range is WIDTH >= 2.
- MSB_FIRST, 1, selects shift order: 1 sends the MSB first, 0 sends the LSB first.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- clear  input  1  asynchronous, active-low reset.
- load_data  input  WIDTH  parallel word to transmit.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a valid bit this cycle.
- frame_start  output  1  high during the first bit of a word.
- last_bit  output  1  high during the final bit of a word.

Behaviour:
- Registers: shift register sreg[WIDTH-1:0], bit counter cnt of width $clog2(WIDTH), state register.
- States: IDLE and SHIFT.
- Reset (clear=0), effective immediately and asynchronously:
  - state=IDLE, cnt=0, sreg=0.
  - ser_out=0, ser_valid=0, frame_start=0, last_bit=0.
  - load_ready=1, because it is decoded from IDLE.
- Accept condition: load_valid && load_ready sampled at a rising edge. At that edge:
  - sreg <= load_data, cnt <= 0, state <= SHIFT.
- Latency: the first bit appears on ser_out in the cycle after acceptance (one clock).
- Bit ordering:
  - MSB_FIRST=1: bit index sent at count k is WIDTH-1-k.
  - MSB_FIRST=0: bit index sent at count k is k.
  - Implementation is free to either index sreg or shift it.
- SHIFT state:
  - ser_valid=1; ser_out is the selected bit.
  - frame_start = (cnt==0); last_bit = (cnt==WIDTH-1).
  - cnt increments by 1 each clock.
- IDLE state: ser_valid=0, ser_out=0, frame_start=0, last_bit=0.
- load_ready = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1). This is combinational from registered state only; it must not depend on load_valid.
- End of word (last bit cycle, cnt==WIDTH-1):
  - Accept at that edge: reload sreg, cnt <= 0, remain in SHIFT. The next cycle is the first bit of the new word with frame_start=1, so there are no idle cycles between words.
  - No accept: state <= IDLE, cnt <= 0.
- load_valid during SHIFT with cnt<WIDTH-1: load_ready=0, so the word is not taken. load_data may change freely; the upstream must hold the word until accepted.
- A word is exactly WIDTH valid bits. The counter never wraps past WIDTH-1.
- Reset mid-word aborts the word. No partial-word recovery; after clear deasserts the block starts in IDLE.
- Outputs ser_out, ser_valid, frame_start and last_bit are registered or decoded from registers only, so they are glitch-free for the downstream chain.
- All sequential assignments are non-blocking, so statement order inside the always block is irrelevant.

Decomposition:
- Shared package:
  - default WIDTH constant (4).
  - MSB_FIRST default constant.
  - state encoding constants: IDLE=1'b0, SHIFT=1'b1.
- No sub-module needed; a single always block plus combinational output decode is sufficient.
- The verification bench instantiates this block feeding the existing 4-stage serial shift-register module as the loopback sink.

Test Plan (WIDTH=4):
1. MSB_FIRST=1, accept 4'b1011 at edge T -> ser_out=1,0,1,1 in cycles T+1..T+4; ser_valid=1 in T+1..T+4, 0 in T+5; frame_start only in T+1; last_bit only in T+4; load_ready=1 only at T+4 and from T+5 on.
2. MSB_FIRST=0, accept 4'b1011 -> ser_out=1,1,0,1; framing identical to test 1.
3. Back-to-back: 4'b1011 accepted at T, 4'b0110 held valid and accepted at T+4 -> 8 contiguous ser_valid cycles (MSB first: 1,0,1,1,0,1,1,0); frame_start at T+1 and T+5; last_bit at T+4 and T+8.
4. Hold off: load_valid=1 with 4'b1111 during cycles T+1..T+3 of an in-flight word -> not accepted, current word bits unchanged. Accepted at T+4 -> 1,1,1,1 in T+5..T+8.
5. Reset mid-word: assert clear=0 asynchronously in cycle T+2 -> ser_valid, ser_out, frame_start and last_bit go to 0 without waiting for a clock edge. After release: IDLE, load_ready=1, next word transmits cleanly from bit 0.
6. Loopback into the 4-stage chain: send 4'b1011 MSB-first -> chain output E reproduces 1,0,1,1 delayed 4 cycles from ser_out.
